// File: rtl/prl_tx_req_queue.sv
// PE-to-PL transmit request queue: buffers up to DEPTH requests from the policy engine and
// issues them one at a time to the PRL TX state machine, returning one ack/result per request.
// Includes an ack watchdog, a flush (abort) path, overflow reporting and a queue-level output.
module prl_tx_req_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INFO_W      = 5,
  parameter int unsigned EX_INFO_W   = 36,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pe2pl_tx_en,
  input  logic [6:0]           pe2pl_tx_type,
  input  logic [2:0]           pe2pl_tx_sop_type,
  input  logic [INFO_W-1:0]    pe2pl_tx_info,
  input  logic [EX_INFO_W-1:0] pe2pl_tx_ex_info,
  input  logic                 pe2pl_tx_flush,
  output logic                 pe2pl_tx_ready,
  output logic                 pl2pe_tx_ack,
  output logic [1:0]           pl2pe_tx_result,
  output logic                 pl2pe_tx_overflow,
  input  logic                 prl_tx_st_message_if_ack,
  input  logic [1:0]           prl_tx_st_message_if_ack_result,
  output logic                 prl_tx_if_en,
  output logic [2:0]           prl_tx_if_sop_type,
  output logic [1:0]           prl_tx_if_message_type,
  output logic [4:0]           prl_tx_if_header_type,
  output logic [INFO_W-1:0]    prl_tx_if_info,
  output logic [EX_INFO_W-1:0] prl_tx_if_ex_info,
  output logic [LVL_W-1:0]     prl_tx_q_level
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Entry layout, MSB first: type[6:0], sop[2:0], info, ex_info
  localparam int unsigned EntW = 7 + 3 + INFO_W + EX_INFO_W;
  localparam logic [LVL_W-1:0] FullLvl = LVL_W'(DEPTH);
  // Last watchdog count before self-abort; unused when the watchdog is disabled
  localparam logic [31:0] WdLast = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [31:0]         wdog_q, wdog_d;
  logic                ack_q, ack_d;
  logic [1:0]          result_q, result_d;
  logic                ovf_q, ovf_d;
  logic [EntW-1:0]     mem_q [DEPTH];

  logic                full;
  logic                in_issue;
  logic                push;
  logic                pop;
  logic                timeout;
  logic [EntW-1:0]     wr_ent;
  logic [EntW-1:0]     head_ent;

  assign full     = (level_q == FullLvl);
  assign in_issue = (state_q == StIssue);
  // Flush discards a same-cycle push without flagging overflow
  assign push     = pe2pl_tx_en && !full && !pe2pl_tx_flush;
  assign timeout  = (TIMEOUT_CYC != 0) && in_issue && (wdog_q == WdLast);
  assign pop      = in_issue && (prl_tx_st_message_if_ack || timeout) && !pe2pl_tx_flush;
  assign wr_ent   = {pe2pl_tx_type, pe2pl_tx_sop_type, pe2pl_tx_info, pe2pl_tx_ex_info};
  assign head_ent = mem_q[rd_ptr_q];

  // Storage array write; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_ent;
    end
  end

  // Next-state for pointers, level, watchdog and PE-side completion outputs
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    wdog_d   = wdog_q;
    ack_d    = 1'b0;
    result_d = result_q;
    ovf_d    = 1'b0;
    if (pe2pl_tx_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      wdog_d   = '0;
      // Aborting an in-flight request still owes the PE a completion
      if (in_issue) begin
        ack_d    = 1'b1;
        result_d = 2'b11;
      end
    end else begin
      ovf_d = pe2pl_tx_en && full;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        ack_d    = 1'b1;
        // A real ack wins over a same-cycle watchdog expiry
        result_d = prl_tx_st_message_if_ack ? prl_tx_st_message_if_ack_result : 2'b11;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (in_issue && !pop) begin
        wdog_d = wdog_q + 32'd1;
      end else begin
        wdog_d = '0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      wdog_q   <= '0;
      ack_q    <= 1'b0;
      result_q <= 2'b00;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      wdog_q   <= wdog_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Issue FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue FSM next state; GAP guarantees one en-low cycle between requests
  always_comb begin
    state_d = state_q;
    if (pe2pl_tx_flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (level_q != '0) state_d = StIssue;
        StIssue: if (pop) state_d = StGap;
        StGap:   state_d = (level_q != '0) ? StIssue : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Issue FSM outputs: head entry is only exposed while a request is in flight
  always_comb begin
    prl_tx_if_en           = 1'b0;
    prl_tx_if_message_type = '0;
    prl_tx_if_header_type  = '0;
    prl_tx_if_sop_type     = '0;
    prl_tx_if_info         = '0;
    prl_tx_if_ex_info      = '0;
    if (in_issue) begin
      prl_tx_if_en           = 1'b1;
      prl_tx_if_message_type = head_ent[EntW-1 -: 2];
      prl_tx_if_header_type  = head_ent[EntW-3 -: 5];
      prl_tx_if_sop_type     = head_ent[EntW-8 -: 3];
      prl_tx_if_info         = head_ent[EX_INFO_W +: INFO_W];
      prl_tx_if_ex_info      = head_ent[EX_INFO_W-1:0];
    end
  end

  assign pe2pl_tx_ready    = !full;
  assign pl2pe_tx_ack      = ack_q;
  assign pl2pe_tx_result   = result_q;
  assign pl2pe_tx_overflow = ovf_q;
  assign prl_tx_q_level    = level_q;

endmodule

// File: doc/prl_tx_req_queue.md
Name: prl_tx_req_queue

Overview:
- Parametrised successor of the single-entry PE-to-PL TX message interface.
- Buffers up to DEPTH transmit requests from the policy engine in a FIFO and issues them one at a time to the PRL TX state machine.
- Returns one ack/result to the PE per request, including requests terminated by the block itself.
- Adds an ack watchdog, a flush (abort) path, overflow reporting and a queue-level output.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >=2.
- INFO_W, 5, width of the info field.
- EX_INFO_W, 36, width of the extended-info field.
- TIMEOUT_CYC, 1024, cycles in ISSUE without an ack before self-abort; 0 disables the watchdog.
- LVL_W, $clog2(DEPTH+1), width of the queue-level output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pe2pl_tx_en  in  1  request push strobe, one cycle per request
- pe2pl_tx_type  in  7  [6:5] message type, [4:0] header type
- pe2pl_tx_sop_type  in  3  SOP type
- pe2pl_tx_info  in  INFO_W  request info
- pe2pl_tx_ex_info  in  EX_INFO_W  extended request info
- pe2pl_tx_flush  in  1  abort the in-flight request and empty the queue
- pe2pl_tx_ready  out  1  queue not full (combinational from registered level)
- pl2pe_tx_ack  out  1  one-cycle completion pulse
- pl2pe_tx_result  out  2  completion result, held until the next ack
- pl2pe_tx_overflow  out  1  one-cycle pulse: a push was dropped
- prl_tx_st_message_if_ack  in  1  TX state machine done with the current request
- prl_tx_st_message_if_ack_result  in  2  TX state machine result
- prl_tx_if_en  out  1  request valid to the TX state machine
- prl_tx_if_sop_type  out  3  head-entry SOP type
- prl_tx_if_message_type  out  2  head-entry type[6:5]
- prl_tx_if_header_type  out  5  head-entry type[4:0]
- prl_tx_if_info  out  INFO_W  head-entry info
- prl_tx_if_ex_info  out  EX_INFO_W  head-entry extended info
- prl_tx_q_level  out  LVL_W  number of stored entries, including the in-flight one

Behaviour:
Reset:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- On reset: pointers=0, level=0, state=IDLE, watchdog=0.
- All outputs 0, except pe2pl_tx_ready=1.

Push:
- A push occurs at the clock edge where pe2pl_tx_en=1 and level<DEPTH.
- The push writes {type, sop, info, ex_info} at wr_ptr, then wr_ptr+1 mod DEPTH and level+1.
- pe2pl_tx_en=1 while level==DEPTH: entry is dropped and pl2pe_tx_overflow=1 on the next cycle.

Head outputs:
- prl_tx_if_* fields show the entry at rd_ptr only while state=ISSUE; they are 0 otherwise.
- The head entry is stable for the whole ISSUE period.

State machine (IDLE, ISSUE, GAP):
- IDLE -> ISSUE when level!=0. The entry is visible to the TX state machine one cycle after its push edge.
- ISSUE: prl_tx_if_en=1, watchdog increments every cycle.
- ISSUE -> GAP on prl_tx_st_message_if_ack:
  - pop the entry (rd_ptr+1, level-1),
  - next cycle pl2pe_tx_ack=1 and pl2pe_tx_result=ack_result.
- ISSUE -> GAP on watchdog==TIMEOUT_CYC-1 with no ack (TIMEOUT_CYC!=0): same as an ack with result 2'b11. A real ack in that same cycle wins.
- GAP: prl_tx_if_en=0 for exactly one cycle; watchdog cleared. GAP -> ISSUE if level!=0, else -> IDLE.
- Ack outside ISSUE: ignored, no pulse.

Simultaneous events:
- Push and pop in the same cycle: both take effect, level unchanged.
- pe2pl_tx_ready uses the registered level. A push while full with a same-cycle pop is still dropped and flagged.

Flush (highest priority):
- At the edge where pe2pl_tx_flush=1: pointers=0, level=0, state=IDLE, watchdog=0.
- A push in the same cycle is discarded with no overflow pulse.
- If state was ISSUE: pl2pe_tx_ack=1 with result 2'b11 next cycle. Otherwise no ack.
- A TX state machine ack in the flush cycle is ignored.

Result codes:
- 2'b00..2'b10 are passed through from the TX state machine.
- 2'b11 is produced only by the watchdog or by flush.

Test Plan:
1. Single push (type 7'h23, sop 3'd1, info 5'h11); ack with result 2'b01 after 3 cycles -> prl_tx_if_en high from push+1 for 3 cycles, message_type 2'b01, header_type 5'h03; pl2pe_tx_ack one-cycle pulse, result 2'b01; level returns to 0.
2. Four back-to-back pushes (DEPTH=4), then a 5th push -> ready=0 after the 4th; overflow pulse for the 5th; the four requests are issued in order, each separated by one en-low GAP cycle.
3. Push and ack/pop in the same cycle with level=2 -> level stays 2; the following ISSUE presents the correct next entry.
4. TIMEOUT_CYC=8, no ack -> en high for 8 cycles, then ack pulse with result 2'b11, entry popped; an ack arriving 2 cycles later is ignored.
5. Flush while in ISSUE with level=3, plus a push in the same cycle -> ack result 2'b11 next cycle; level=0, en=0; no overflow; no further issues.
6. Async rst_n assertion mid-ISSUE -> all outputs reset immediately; after release, ready=1, level=0, no ack pulse.
